// File: rtl/scdata_efuse_ctl_gen_if.sv
// Serial efuse-controller side and redundancy-array side of the efuse control block.
interface scdata_efuse_ctl_gen_if #(
  parameter int NSUB = 4,
  parameter int NRID = 6,
  parameter int RIDW = 3
);
  logic                   testmode_l;
  logic                   efc_ashift;
  logic                   efc_dshift;
  logic                   efc_data;
  logic                   err_clr;
  logic                   red_fuse_data;
  logic                   efc_fuse_data;
  logic                   fuse_red_data;
  logic [NSUB*NRID-1:0]   fuse_red_wren;
  logic [RIDW-1:0]        fuse_red_rid;
  logic                   fuse_red_read_shift;
  logic                   busy;
  logic                   addr_err;
  logic                   len_err;

  modport master (
    output testmode_l, efc_ashift, efc_dshift, efc_data, err_clr, red_fuse_data,
    input  efc_fuse_data, fuse_red_data, fuse_red_wren, fuse_red_rid,
           fuse_red_read_shift, busy, addr_err, len_err
  );

  modport slave (
    input  testmode_l, efc_ashift, efc_dshift, efc_data, err_clr, red_fuse_data,
    output efc_fuse_data, fuse_red_data, fuse_red_wren, fuse_red_rid,
           fuse_red_read_shift, busy, addr_err, len_err
  );
endinterface

// File: rtl/scdata_efuse_ctl_gen.sv
// Efuse redundancy-row controller: serial address decode, one-hot row write enables, 2-flop read return.
// Write data/enables lag the dshift cycle by one clock; no backpressure, an address shift aborts any transfer.
module scdata_efuse_ctl_gen #(
  parameter int NSUB = 4,
  parameter int NRID = 6,
  parameter int SUBW = 2,
  parameter int RIDW = 3,
  parameter int DW   = 16
) (
  input logic                   rclk,
  input logic                   arst_l,
  scdata_efuse_ctl_gen_if.slave bus
);
  localparam int AW   = SUBW + RIDW + 1;
  localparam int CW   = $clog2(DW + 1);
  localparam int NW   = NSUB * NRID;
  localparam int IW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int SUBL = SUBW + 1;
  localparam int RIDL = RIDW + 1;
  localparam logic [SUBW:0] NSUB_L = SUBL'(NSUB);
  localparam logic [RIDW:0] NRID_L = RIDL'(NRID);
  localparam logic [CW-1:0] DW_C   = CW'(DW);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_ARMED = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_q, wr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RIDW-1:0] rid_q, rid_d;
  logic            data_q, data_d;
  logic [NW-1:0]   wren_q, wren_d;
  logic            rshift_q, rshift_d;
  logic            rd1_q, rd1_d;
  logic            rd2_q, rd2_d;
  logic            addr_err_q, addr_err_d;
  logic            len_err_q, len_err_d;

  logic [SUBW-1:0] sub_w;
  logic [RIDW-1:0] rid_w;
  logic            range_ok;
  logic            busy_w;
  logic            xfer;
  logic            addr_err_set;
  logic            len_err_set;

  assign sub_w    = addr_q[AW-1:RIDW+1];
  assign rid_w    = addr_q[RIDW:1];
  assign range_ok = ({1'b0, sub_w} < NSUB_L) && ({1'b0, rid_w} < NRID_L);
  assign busy_w   = (state_q == S_WRITE) || (state_q == S_READ);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    rid_d        = rid_q;
    data_d       = data_q;
    wren_d       = '0;
    rshift_d     = 1'b0;
    rd1_d        = bus.red_fuse_data;
    rd2_d        = rd1_q;
    xfer         = 1'b0;
    addr_err_set = 1'b0;
    len_err_set  = 1'b0;

    if (bus.efc_ashift) begin
      addr_d  = {addr_q[AW-2:0], bus.efc_data};
      state_d = S_ADDR;
      if (busy_w && (count_q != DW_C)) len_err_set = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (!range_ok) begin
            addr_err_set = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_ARMED;
            rid_d   = rid_w;
            wr_d    = addr_q[0];
            idx_d   = IW'(sub_w) * IW'(NRID) + IW'(rid_w);
          end
        end
        // The dshift cycle that leaves ARMED also carries the first bit.
        S_ARMED: begin
          if (bus.efc_dshift) begin
            xfer    = 1'b1;
            state_d = wr_q ? S_WRITE : S_READ;
          end
        end
        S_WRITE, S_READ: begin
          if (bus.efc_dshift) begin
            xfer = (count_q != DW_C);
          end else begin
            if (count_q != DW_C) len_err_set = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end

    if (xfer) begin
      count_d = ((state_q == S_ARMED) ? '0 : count_q) + CW'(1);
      if (wr_q) begin
        wren_d[idx_q] = 1'b1;
        data_d        = bus.efc_data;
      end else begin
        rshift_d = 1'b1;
      end
    end

    addr_err_d = (addr_err_q & ~bus.err_clr) | addr_err_set;
    len_err_d  = (len_err_q & ~bus.err_clr) | len_err_set;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      rid_q      <= '0;
      data_q     <= 1'b0;
      wren_q     <= '0;
      rshift_q   <= 1'b0;
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
      addr_err_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      rid_q      <= rid_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      rshift_q   <= rshift_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      addr_err_q <= addr_err_d;
      len_err_q  <= len_err_d;
    end
  end

  // Test-mode gating is combinational so the FSM and datapath keep running.
  assign bus.fuse_red_wren       = wren_q & {NW{bus.testmode_l}};
  assign bus.fuse_red_read_shift = rshift_q & bus.testmode_l;
  assign bus.fuse_red_data       = data_q;
  assign bus.fuse_red_rid        = rid_q;
  assign bus.efc_fuse_data       = rd2_q;
  assign bus.busy                = busy_w;
  assign bus.addr_err            = addr_err_q;
  assign bus.len_err             = len_err_q;
endmodule

// File: tb/tb_scdata_efuse_ctl_gen.sv
// Directed bench for the efuse control block: default instance plus a small NSUB=2/NRID=3/DW=4 instance on shared stimulus.
module tb_scdata_efuse_ctl_gen;
  logic rclk = 1'b0;
  logic arst_l;
  int   n_chk  = 0;
  int   n_pass = 0;

  scdata_efuse_ctl_gen_if #(.NSUB(4), .NRID(6), .RIDW(3)) bus ();
  scdata_efuse_ctl_gen_if #(.NSUB(2), .NRID(3), .RIDW(3)) bus2 ();

  scdata_efuse_ctl_gen dut (.rclk(rclk), .arst_l(arst_l), .bus(bus));
  scdata_efuse_ctl_gen #(.NSUB(2), .NRID(3), .SUBW(2), .RIDW(3), .DW(4))
    dut2 (.rclk(rclk), .arst_l(arst_l), .bus(bus2));

  assign bus2.testmode_l    = bus.testmode_l;
  assign bus2.efc_ashift    = bus.efc_ashift;
  assign bus2.efc_dshift    = bus.efc_dshift;
  assign bus2.efc_data      = bus.efc_data;
  assign bus2.err_clr       = bus.err_clr;
  assign bus2.red_fuse_data = bus.red_fuse_data;

  always #5 rclk = ~rclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic shift_addr(input logic [5:0] a, input logic clr);
    for (int i = 5; i >= 0; i--) begin
      bus.efc_ashift = 1'b1;
      bus.efc_data   = a[i];
      @(negedge rclk);
    end
    bus.efc_ashift = 1'b0;
    bus.efc_data   = 1'b0;
    bus.err_clr    = clr;
    @(negedge rclk);
    bus.err_clr = 1'b0;
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(negedge rclk);
    bus.err_clr = 1'b0;
  endtask

  int          wren_cnt, bad_cnt, rs_cnt, w2_cnt;
  logic [31:0] replay, replay2, rd_seen;
  logic        busy_mid;

  task automatic run_data(input int n, input int idx, input int idx2,
                          input logic [31:0] wdat, input logic [31:0] rdat);
    logic [23:0] exp1;
    logic [5:0]  exp2;
    exp1 = 24'd1 << idx;
    exp2 = 6'd1 << idx2;
    wren_cnt = 0; bad_cnt = 0; rs_cnt = 0; w2_cnt = 0;
    replay = '0; replay2 = '0; rd_seen = '0; busy_mid = 1'b0;
    for (int c = 0; c <= n + 2; c++) begin
      if (bus.fuse_red_wren == exp1) begin
        wren_cnt++;
        replay = {replay[30:0], bus.fuse_red_data};
      end else if (bus.fuse_red_wren != '0) begin
        bad_cnt++;
      end
      if (bus2.fuse_red_wren == exp2) begin
        w2_cnt++;
        replay2 = {replay2[30:0], bus2.fuse_red_data};
      end
      if (bus.fuse_red_read_shift) rs_cnt++;
      if (c >= 2 && c <= n + 1) rd_seen = {rd_seen[30:0], bus.efc_fuse_data};
      if (c == 3) busy_mid = bus.busy;
      if (c < n) begin
        bus.efc_dshift    = 1'b1;
        bus.efc_data      = wdat[n-1-c];
        bus.red_fuse_data = rdat[n-1-c];
      end else begin
        bus.efc_dshift    = 1'b0;
        bus.efc_data      = 1'b0;
        bus.red_fuse_data = 1'b0;
      end
      @(negedge rclk);
    end
  endtask

  initial begin
    arst_l            = 1'b0;
    bus.testmode_l    = 1'b1;
    bus.efc_ashift    = 1'b0;
    bus.efc_dshift    = 1'b0;
    bus.efc_data      = 1'b0;
    bus.err_clr       = 1'b0;
    bus.red_fuse_data = 1'b0;
    #2;
    check("rst_wren",  bus.fuse_red_wren, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_errs",  {bus.addr_err, bus.len_err}, 0);
    check("rst_rid",   bus.fuse_red_rid, 0);
    check("rst_outs",  {bus.fuse_red_data, bus.efc_fuse_data, bus.fuse_red_read_shift}, 0);
    @(negedge rclk);
    arst_l = 1'b1;
    @(negedge rclk);

    // Write sub 2 rid 5 -> wren[17]; small instance sees sub 2 as out of range.
    shift_addr(6'b10_101_1, 1'b0);
    check("wr_rid", bus.fuse_red_rid, 5);
    check("sweep_sub2_err", bus2.addr_err, 1);
    run_data(16, 17, 5, 32'hA5C3, 32'h0);
    check("wr_cnt",    wren_cnt, 16);
    check("wr_bad",    bad_cnt, 0);
    check("wr_replay", replay, 32'hA5C3);
    check("wr_busy",   busy_mid, 1);
    check("wr_errs",   {bus.addr_err, bus.len_err}, 0);
    check("wr_idle",   bus.busy, 0);

    // Data shifts after the transfer are ignored until a new address arrives.
    run_data(4, 17, 5, 32'hF, 32'h0);
    check("idle_cnt",  wren_cnt + bad_cnt, 0);
    check("idle_busy", busy_mid, 0);
    check("idle_len",  bus.len_err, 0);

    // rid 6 is out of range.
    shift_addr(6'b00_110_1, 1'b0);
    check("aerr_set",  bus.addr_err, 1);
    check("aerr_busy", bus.busy, 0);
    run_data(4, 6, 5, 32'hF, 32'h0);
    check("aerr_wren", wren_cnt + bad_cnt, 0);
    clear_errs();
    check("aerr_clr",  bus.addr_err, 0);
    shift_addr(6'b00_110_1, 1'b1);
    check("aerr_setwins", bus.addr_err, 1);
    clear_errs();

    // Read sub 1 rid 3.
    shift_addr(6'b01_011_0, 1'b0);
    check("rd_rid", bus.fuse_red_rid, 3);
    run_data(16, 9, 5, 32'h0, 32'h1234);
    check("rd_shift", rs_cnt, 16);
    check("rd_data",  rd_seen, 32'h1234);
    check("rd_wren",  wren_cnt + bad_cnt, 0);
    check("rd_errs",  {bus.addr_err, bus.len_err}, 0);
    clear_errs();

    // Short write to sub 3 rid 0 -> wren[18] for 9 cycles then len_err.
    shift_addr(6'b11_000_1, 1'b0);
    run_data(9, 18, 5, 32'h1AB, 32'h0);
    check("short_cnt",    wren_cnt, 9);
    check("short_replay", replay, 32'h1AB);
    check("short_len",    bus.len_err, 1);
    clear_errs();
    check("short_clr",    bus.len_err, 0);

    // Long write: only the first 16 bits land, no error.
    shift_addr(6'b11_000_1, 1'b0);
    run_data(20, 18, 5, 32'hBEEF5, 32'h0);
    check("long_cnt",    wren_cnt, 16);
    check("long_replay", replay, 32'hBEEF);
    check("long_len",    bus.len_err, 0);

    // Address shift mid-write aborts with len_err and drops wren next cycle.
    shift_addr(6'b10_101_1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.efc_dshift = 1'b1;
      bus.efc_data   = 1'b1;
      @(negedge rclk);
    end
    check("abort_pre", bus.fuse_red_wren, 32'h20000);
    bus.efc_ashift = 1'b1;
    bus.efc_data   = 1'b0;
    @(negedge rclk);
    check("abort_wren", bus.fuse_red_wren, 0);
    check("abort_len",  bus.len_err, 1);
    check("abort_busy", bus.busy, 0);
    bus.efc_ashift = 1'b0;
    bus.efc_dshift = 1'b0;
    @(negedge rclk);
    clear_errs();

    // testmode_l low blocks wren but the FSM and data register still run.
    shift_addr(6'b10_101_1, 1'b0);
    bus.testmode_l = 1'b0;
    run_data(16, 17, 5, 32'hA5C3, 32'h0);
    check("tm_wren", wren_cnt + bad_cnt, 0);
    check("tm_busy", busy_mid, 1);
    check("tm_data", bus.fuse_red_data, 1);
    check("tm_len",  bus.len_err, 0);
    bus.testmode_l = 1'b1;

    // Asynchronous reset mid-write.
    shift_addr(6'b10_101_1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.efc_dshift = 1'b1;
      bus.efc_data   = 1'b1;
      @(negedge rclk);
    end
    check("mrst_pre", bus.fuse_red_wren, 32'h20000);
    #2 arst_l = 1'b0;
    #1;
    check("mrst_wren", bus.fuse_red_wren, 0);
    check("mrst_outs", {bus.busy, bus.fuse_red_data, bus.fuse_red_rid}, 0);
    bus.efc_dshift = 1'b0;
    bus.efc_data   = 1'b0;
    @(negedge rclk);
    arst_l = 1'b1;

    // Normal operation right after reset; also exercises the small instance (sub 1 rid 2 -> bit 5).
    shift_addr(6'b01_010_1, 1'b0);
    check("sweep_rid", bus2.fuse_red_rid, 2);
    run_data(16, 8, 5, 32'h9A5C, 32'h0);
    check("post_cnt",      wren_cnt, 16);
    check("post_replay",   replay, 32'h9A5C);
    check("sweep_cnt",     w2_cnt, 4);
    check("sweep_replay",  replay2, 32'h9);
    check("sweep_errs",    {bus2.addr_err, bus2.len_err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
